// File: rtl/musa_pkg.sv
// Shared definitions for the MUSA fetch path.
//   - op encodings presented by the control unit on the sequencer's op port
//   - fetch sequencer state enum
//   - default address width
package musa_pkg;

    localparam int MUSA_ADDR_W = 18;

    localparam logic [2:0] FS_NEXT        = 3'd0;
    localparam logic [2:0] FS_JUMP_IMM    = 3'd1;
    localparam logic [2:0] FS_JUMP_REG    = 3'd2;
    localparam logic [2:0] FS_BRANCH_FLAG = 3'd3;
    localparam logic [2:0] FS_CALL        = 3'd4;
    localparam logic [2:0] FS_RETURN      = 3'd5;
    // Suffixed so it does not collide with the FS_HALT state literal below.
    localparam logic [2:0] FS_HALT_OP     = 3'd6;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_HALT  = 2'd1,
        FS_FAULT = 2'd2
    } fs_state_e;

endpackage

// File: rtl/musa_ras.sv
// Return-address stack: LIFO of DEPTH entries, W bits wide.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears count only)
//   push, push_data   write push_data above the current top
//   pop               discard the current top
//   top               entry at count-1 (don't-care when empty)
//   count             number of valid entries
//   full, empty       count == DEPTH / count == 0
// Caller guarantees push only when !full, pop only when !empty, never both.
module musa_ras #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [W-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] top_ptr;

    assign top_ptr = count - 1'b1;
    assign top     = mem[top_ptr[IDX_W-1:0]];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    // Storage is intentionally not reset; only the pointer is.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[count[IDX_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push) begin
            count <= count + 1'b1;
        end else if (pop) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/musa_fetch_sequencer.sv
// Next-PC sequencer for the MUSA core: PC register, incrementer, branch
// selector and return-address stack with halt and stack-fault detection.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   advance, op        execute op this cycle (op encodings in musa_pkg)
//   imm_addr           target for JUMP_IMM, BRANCH_FLAG, CALL
//   reg_addr           target for JUMP_REG
//   flag               branch condition for BRANCH_FLAG
//   pc                 registered PC, drives instruction memory address
//   ras_count          valid return-stack entries
//   halted             state is HALT
//   fault_ovf/unf      sticky stack overflow / underflow
//
// state    | meaning
// FS_RUN   | executing ops when advance=1
// FS_HALT  | HALT op executed; terminal until reset
// FS_FAULT | stack overflow/underflow; terminal until reset
module musa_fetch_sequencer
    import musa_pkg::*;
#(
    parameter int              ADDR_W    = MUSA_ADDR_W,
    parameter int              RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             advance,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                imm_addr,
    input  logic [ADDR_W-1:0]                reg_addr,
    input  logic                             flag,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             halted,
    output logic                             fault_ovf,
    output logic                             fault_unf
);
    fs_state_e         state;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;
    logic              run_op;

    // Wraps modulo 2^ADDR_W by width; also the pushed return address.
    assign pc_inc = pc + 1'b1;
    assign run_op = (state == FS_RUN) && advance;

    always_comb begin
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (run_op) begin
            ras_push = (op == FS_CALL)   && !ras_full;
            ras_pop  = (op == FS_RETURN) && !ras_empty;
        end
    end

    musa_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FS_RUN;
            pc        <= RESET_PC;
            halted    <= 1'b0;
            fault_ovf <= 1'b0;
            fault_unf <= 1'b0;
        end else if (run_op) begin
            case (op)
                FS_JUMP_IMM:    pc <= imm_addr;
                FS_JUMP_REG:    pc <= reg_addr;
                FS_BRANCH_FLAG: pc <= flag ? imm_addr : pc_inc;
                FS_CALL: begin
                    if (ras_full) begin
                        fault_ovf <= 1'b1;
                        state     <= FS_FAULT;
                    end else begin
                        pc <= imm_addr;
                    end
                end
                FS_RETURN: begin
                    if (ras_empty) begin
                        fault_unf <= 1'b1;
                        state     <= FS_FAULT;
                    end else begin
                        pc <= ras_top;
                    end
                end
                FS_HALT_OP: begin
                    halted <= 1'b1;
                    state  <= FS_HALT;
                end
                // NEXT and the reserved encoding
                default:        pc <= pc_inc;
            endcase
        end
    end

endmodule
